// File: rtl/regflgwei_loader.sv
// rtl/regflgwei_loader.sv - fills per-PE flag/weight register files from the weight SRAM
// One job: clear and load each enabled PE in ascending order from contiguous SRAM rows.
module regflgwei_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int WR_NUM     = 2,
    parameter int RD_NUM     = 27,
    parameter int NUM_PE     = 4,
    parameter int SRAM_AW    = 10
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_cfg_val,
    output logic                         o_cfg_rdy,
    input  logic [SRAM_AW-1:0]           i_cfg_base_addr,
    input  logic [NUM_PE-1:0]            i_cfg_pe_mask,
    output logic                         o_busy,
    output logic                         o_job_done,
    output logic                         o_sram_rd_en,
    output logic [SRAM_AW-1:0]           o_sram_rd_addr,
    input  logic [DATA_WIDTH*WR_NUM-1:0] i_sram_rd_data,
    output logic [NUM_PE-1:0]            o_regf_reset,
    output logic [NUM_PE-1:0]            o_regf_val,
    input  logic [NUM_PE-1:0]            i_regf_rdy,
    output logic [DATA_WIDTH*WR_NUM-1:0] o_regf_data,
    input  logic [NUM_PE-1:0]            i_regf_full
);
    localparam int ROW_W = DATA_WIDTH * WR_NUM;
    localparam int BEATS = (RD_NUM + 1) / WR_NUM;
    localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int BC_W  = $clog2(BEATS + 1);

    if ((RD_NUM + 1) % WR_NUM != 0) begin : g_bad_beats
        $error("RD_NUM+1 must be a multiple of WR_NUM");
    end
    if (NUM_PE < 1 || NUM_PE > 16) begin : g_bad_num_pe
        $error("NUM_PE must be in 1..16");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_CLR   = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_WAITF = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         r_state;
    logic [PE_W-1:0]    r_pe;
    logic [NUM_PE-1:0]  r_mask;
    logic [SRAM_AW-1:0] r_addr;
    logic [BC_W-1:0]    r_beat_cnt;
    logic [BC_W-1:0]    r_issued;
    logic [ROW_W-1:0]   r_fifo0;
    logic [ROW_W-1:0]   r_fifo1;
    logic [1:0]         r_count;
    logic               r_inflight;

    logic [NUM_PE-1:0]  w_pe_onehot;
    logic               w_last_pe;
    logic               w_in_load;
    logic               w_have;
    logic               w_accept;
    logic               w_rd_en;
    logic               w_push;
    logic               w_pop;
    logic               w_last_beat;

    assign w_pe_onehot = NUM_PE'(1) << r_pe;
    assign w_last_pe   = (r_pe == PE_W'(NUM_PE - 1));
    assign w_in_load   = (r_state == S_LOAD);
    // The returning row is offered directly while it is still in flight, giving one beat per cycle.
    assign w_have      = (r_count != 2'd0) || r_inflight;
    assign w_accept    = w_in_load && w_have && i_regf_rdy[r_pe];
    assign w_rd_en     = w_in_load && (r_issued < BC_W'(BEATS))
                         && ((3'(r_count) + 3'(r_inflight)) < 3'd2);
    assign w_push      = r_inflight && !(w_accept && (r_count == 2'd0));
    assign w_pop       = w_accept && (r_count != 2'd0);
    assign w_last_beat = w_accept && (r_beat_cnt == BC_W'(BEATS - 1));

    assign o_cfg_rdy      = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_job_done     = (r_state == S_DONE);
    assign o_sram_rd_en   = w_rd_en;
    assign o_sram_rd_addr = r_addr;
    assign o_regf_reset   = (r_state == S_CLR) ? w_pe_onehot : '0;
    assign o_regf_val     = (w_in_load && w_have) ? w_pe_onehot : '0;
    assign o_regf_data    = (r_count != 2'd0) ? r_fifo0 : (r_inflight ? i_sram_rd_data : '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pe       <= '0;
            r_mask     <= '0;
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_issued   <= '0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_cfg_val) begin
                    r_addr  <= i_cfg_base_addr;
                    r_mask  <= i_cfg_pe_mask;
                    r_pe    <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (r_mask[r_pe])   r_state <= S_CLR;
                    else if (w_last_pe) r_state <= S_DONE;
                    else                r_pe    <= r_pe + PE_W'(1);
                end
                S_CLR: begin
                    r_beat_cnt <= '0;
                    r_issued   <= '0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: if (w_last_beat) r_state <= S_WAITF;
                // A stale full flag is only looked at here, after the new set has been written.
                S_WAITF: if (i_regf_full[r_pe]) begin
                    if (w_last_pe) r_state <= S_DONE;
                    else begin
                        r_pe    <= r_pe + PE_W'(1);
                        r_state <= S_SCAN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_rd_en) begin
                r_addr   <= r_addr + SRAM_AW'(1);
                r_issued <= r_issued + BC_W'(1);
            end
            if (w_accept) r_beat_cnt <= r_beat_cnt + BC_W'(1);
            r_inflight <= w_rd_en;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && w_pop) begin
            if (r_count == 2'd2) begin
                r_fifo0 <= r_fifo1;
                r_fifo1 <= i_sram_rd_data;
            end else begin
                r_fifo0 <= i_sram_rd_data;
            end
        end else if (w_pop) begin
            r_fifo0 <= r_fifo1;
        end else if (w_push) begin
            if (r_count == 2'd0) r_fifo0 <= i_sram_rd_data;
            else                 r_fifo1 <= i_sram_rd_data;
        end
    end
endmodule

// File: tb/tb_regflgwei_loader.sv
// tb/tb_regflgwei_loader.sv - scoreboard bench for regflgwei_loader
module tb_regflgwei_loader;
    localparam int NPE = 4;
    localparam int AW = 10;
    localparam int BEATS = 14;
    localparam int RW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic           cfg_val = 1'b0;
    logic           cfg_rdy;
    logic [AW-1:0]  cfg_base_addr = '0;
    logic [NPE-1:0] cfg_pe_mask = '0;
    logic           busy;
    logic           job_done;
    logic           sram_rd_en;
    logic [AW-1:0]  sram_rd_addr;
    logic [RW-1:0]  sram_rd_data = '0;
    logic [NPE-1:0] regf_reset;
    logic [NPE-1:0] regf_val;
    logic [NPE-1:0] regf_rdy = '1;
    logic [RW-1:0]  regf_data;
    logic [NPE-1:0] regf_full = '0;

    regflgwei_loader dut (
        .i_clk(clk), .i_reset(reset), .i_cfg_val(cfg_val), .o_cfg_rdy(cfg_rdy),
        .i_cfg_base_addr(cfg_base_addr), .i_cfg_pe_mask(cfg_pe_mask), .o_busy(busy),
        .o_job_done(job_done), .o_sram_rd_en(sram_rd_en), .o_sram_rd_addr(sram_rd_addr),
        .i_sram_rd_data(sram_rd_data), .o_regf_reset(regf_reset), .o_regf_val(regf_val),
        .i_regf_rdy(regf_rdy), .o_regf_data(regf_data), .i_regf_full(regf_full)
    );

    function automatic logic [RW-1:0] row_data(input int r);
        return {32'(r) ^ 32'hDEAD0000, 32'(r) + 32'h0000_1000};
    endfunction

    always @(posedge clk) if (sram_rd_en) sram_rd_data <= row_data(int'(sram_rd_addr));

    typedef struct { int pe; logic [RW-1:0] data; bit b2b; } beat_t;
    beat_t sb_q[$];
    int    clr_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, last_acc = 0, issued = 0, accepted = 0, rd_total = 0, done_cnt = 0;
    int pe_beats[NPE];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected clears and beats whenever the DUT presents them.
    always @(negedge clk) begin
        beat_t e;
        int    p;
        cyc++;
        if (reset) begin
            sb_q.delete();
            clr_q.delete();
            issued = 0;
            accepted = 0;
        end else begin
            if (sram_rd_en) begin
                issued++;
                rd_total++;
                chk("outstanding_le2", 64'(issued - accepted <= 2), 64'd1);
            end
            if (regf_reset != 0) begin
                if (clr_q.size() == 0) chk("clr_unexpected", 64'(regf_reset), 64'd0);
                else begin
                    p = clr_q.pop_front();
                    chk("clr_pe", 64'(regf_reset), 64'(1 << p));
                    regf_full[p] = 1'b0;
                    pe_beats[p] = 0;
                end
                chk("clr_val_excl", 64'(regf_val), 64'd0);
            end
            if ((regf_val & regf_rdy) != 0) begin
                if (sb_q.size() == 0) chk("beat_unexpected", 64'(regf_val), 64'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("beat_pe", 64'(regf_val), 64'(1 << e.pe));
                    chk("beat_data", regf_data, e.data);
                    if (e.b2b) chk("beat_gap", 64'(cyc - last_acc), 64'd1);
                    last_acc = cyc;
                    accepted++;
                    pe_beats[e.pe]++;
                    if (pe_beats[e.pe] == BEATS) regf_full[e.pe] = 1'b1;
                end
            end
            if (job_done) done_cnt++;
        end
    end

    task automatic issue(input int base, input logic [NPE-1:0] mask, input bit b2b);
        int j = 0;
        for (int pe = 0; pe < NPE; pe++) begin
            if (mask[pe]) begin
                clr_q.push_back(pe);
                for (int b = 0; b < BEATS; b++)
                    sb_q.push_back('{pe, row_data((base + j * BEATS + b) % (1 << AW)), b2b && (b != 0)});
                j++;
            end
        end
        cfg_base_addr = AW'(base);
        cfg_pe_mask = mask;
        cfg_val = 1'b1;
        @(posedge clk); #1;
        cfg_val = 1'b0;
        cfg_base_addr = AW'(999);
        cfg_pe_mask = '1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!job_done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic finish_job(input int exp_done);
        int n;
        wait_done(n);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(job_done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("clr_drained", 64'(clr_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic check_idle_outputs();
        chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(sram_rd_addr), 64'd0);
        chk("rst_regf_reset", 64'(regf_reset), 64'd0);
        chk("rst_regf_val", 64'(regf_val), 64'd0);
        chk("rst_regf_data", regf_data, 64'd0);
    endtask

    initial begin
        int n, rd0, acc0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_outputs();

        issue(0, 4'b1111, 1'b1);
        finish_job(1);

        issue(100, 4'b1010, 1'b1);
        finish_job(2);

        // Stall PE0 for five cycles while beat 3 (row 403) is presented.
        acc0 = accepted;
        issue(400, 4'b0001, 1'b0);
        n = 0;
        while (accepted - acc0 != 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_timeout", 64'(n < 200), 64'd1);
        regf_rdy[0] = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            chk("stall_val", 64'(regf_val), 64'd1);
            chk("stall_data", regf_data, row_data(403));
            @(posedge clk); #1;
        end
        regf_rdy[0] = 1'b1;
        finish_job(3);

        issue(1020, 4'b0001, 1'b1);
        finish_job(4);

        rd0 = rd_total;
        issue(0, 4'b0000, 1'b0);
        wait_done(n);
        chk("mask0_done_latency", 64'(n + 1), 64'(NPE + 1));
        chk("mask0_no_reads", 64'(rd_total - rd0), 64'd0);
        @(posedge clk); #1;
        chk("mask0_done_count", 64'(done_cnt), 64'd5);

        issue(200, 4'b1111, 1'b1);
        n = 0;
        while (!(regf_val == 4'b0010 && pe_beats[1] >= 4) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pe1_load_timeout", 64'(n < 500), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs();
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_val", 64'(regf_val), 64'd0);

        issue(300, 4'b0110, 1'b1);
        finish_job(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
